// File: rtl/pipe_stage_reg.sv
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Valid/ready pipeline stage register with flush, rdy freeze, x0
//             write suppression and NOP presentation when empty. The optional
//             2-entry skid buffer (registered in_ready) is enabled by defining
//             PIPE_STAGE_SKID_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
  parameter int                 DATA_W   = 128,
  parameter int                 ADDR_W   = 5,
  parameter logic [DATA_W-1:0]  NOP_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_w_addr,
  input  logic              in_w_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_w_addr,
  output logic              out_w_req,
  output logic [1:0]        count
);

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_data;
  logic [ADDR_W-1:0] r_main_addr;
  logic              r_main_wreq;

  logic              w_cap_wreq;
  logic              w_in_xfer;
  logic              w_out_xfer;

  // A write to x0 is dropped at capture so it can never reach the register file.
  assign w_cap_wreq = in_w_req & (in_w_addr != '0);
  assign w_in_xfer  = rdy & in_valid & in_ready & ~flush;
  assign w_out_xfer = rdy & r_main_valid & out_ready;

  assign out_valid  = r_main_valid;
  assign out_data   = r_main_data;
  assign out_w_addr = r_main_addr;
  assign out_w_req  = r_main_wreq;

`ifdef PIPE_STAGE_SKID_EN
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_data;
  logic [ADDR_W-1:0] r_skid_addr;
  logic              r_skid_wreq;

  // Skid valid implies main valid, so it alone marks the full state.
  assign in_ready = ~rst & rdy & ~r_skid_valid;
  assign count    = {r_skid_valid, r_main_valid & ~r_skid_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= NOP_DATA;
      r_main_addr  <= '0;
      r_main_wreq  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= NOP_DATA;
      r_skid_addr  <= '0;
      r_skid_wreq  <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        r_main_valid <= 1'b0;
        r_main_data  <= NOP_DATA;
        r_main_addr  <= '0;
        r_main_wreq  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_skid_data  <= NOP_DATA;
        r_skid_addr  <= '0;
        r_skid_wreq  <= 1'b0;
      end else if (r_skid_valid) begin
        if (w_out_xfer) begin
          r_main_data  <= r_skid_data;
          r_main_addr  <= r_skid_addr;
          r_main_wreq  <= r_skid_wreq;
          r_skid_valid <= 1'b0;
          r_skid_data  <= NOP_DATA;
          r_skid_addr  <= '0;
          r_skid_wreq  <= 1'b0;
        end
      end else if (r_main_valid) begin
        if (w_out_xfer && w_in_xfer) begin
          r_main_data <= in_data;
          r_main_addr <= in_w_addr;
          r_main_wreq <= w_cap_wreq;
        end else if (w_out_xfer) begin
          r_main_valid <= 1'b0;
          r_main_data  <= NOP_DATA;
          r_main_addr  <= '0;
          r_main_wreq  <= 1'b0;
        end else if (w_in_xfer) begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= in_data;
          r_skid_addr  <= in_w_addr;
          r_skid_wreq  <= w_cap_wreq;
        end
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
        r_main_addr  <= in_w_addr;
        r_main_wreq  <= w_cap_wreq;
      end
    end
  end
`else
  assign in_ready = ~rst & rdy & (~r_main_valid | out_ready);
  assign count    = {1'b0, r_main_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_main_data  <= NOP_DATA;
      r_main_addr  <= '0;
      r_main_wreq  <= 1'b0;
    end else if (rdy) begin
      if (flush) begin
        r_main_valid <= 1'b0;
        r_main_data  <= NOP_DATA;
        r_main_addr  <= '0;
        r_main_wreq  <= 1'b0;
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
        r_main_addr  <= in_w_addr;
        r_main_wreq  <= w_cap_wreq;
      end else if (w_out_xfer) begin
        r_main_valid <= 1'b0;
        r_main_data  <= NOP_DATA;
        r_main_addr  <= '0;
        r_main_wreq  <= 1'b0;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Directed self-checking bench for pipe_stage_reg (both builds).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

  localparam int                DATA_W = 16;
  localparam int                ADDR_W = 5;
  localparam logic [DATA_W-1:0] NOP    = 16'hA5A5;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0]        MAXC   = 2'd2;
  localparam bit                SKID   = 1'b1;
`else
  localparam logic [1:0]        MAXC   = 2'd1;
  localparam bit                SKID   = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, rdy, flush, in_valid, out_ready, in_w_req;
  logic              in_ready, out_valid, out_w_req;
  logic [DATA_W-1:0] in_data, out_data;
  logic [ADDR_W-1:0] in_w_addr, out_w_addr;
  logic [1:0]        count;

  int vectors = 0;
  int errors  = 0;

  logic              last_acc, last_emit;
  logic [DATA_W-1:0] last_emit_data;

  pipe_stage_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NOP_DATA(NOP)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_w_addr(in_w_addr), .in_w_req(in_w_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_w_addr(out_w_addr), .out_w_req(out_w_req), .count(count)
  );

  always #5 clk = ~clk;

  // Handshakes are sampled mid-cycle; checks happen 1ns after the rising edge.
  task automatic tick;
    @(negedge clk);
    last_acc       = rdy & in_valid & in_ready & ~flush;
    last_emit      = rdy & out_valid & out_ready;
    last_emit_data = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] vals [2];
    vals[0] = a;
    vals[1] = b;
    out_ready = 1'b0;
    in_w_addr = 5'd2;
    in_w_req  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      for (int k = 0; k < 3; k++) begin
        tick();
        if (last_acc) break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_w_addr = '0; in_w_req = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0; #1;
    vectors++;
    if (count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    vectors++;
    if (out_data !== NOP) begin errors++; $display("FAIL reset_out_data: got %h exp %h", out_data, NOP); end
    vectors++;
    if (out_w_addr !== '0 || out_w_req !== 1'b0) begin
      errors++; $display("FAIL reset_wdesc: got addr %0d req %b exp 0 0", out_w_addr, out_w_req);
    end
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b exp 1", in_ready); end
  endtask

  task automatic test_stream;
    out_ready = 1'b1; in_w_addr = 5'd3; in_w_req = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DATA_W'(i);
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== DATA_W'(i)) begin
        errors++; $display("FAIL stream_data[%0d]: got v%b %h exp v1 %h", i, out_valid, out_data, i);
      end
      vectors++;
      if (out_w_req !== 1'b1 || out_w_addr !== 5'd3 || count !== 2'd1) begin
        errors++; $display("FAIL stream_desc[%0d]: got req %b addr %0d cnt %0d exp 1 3 1", i, out_w_req, out_w_addr, count);
      end
    end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out_data !== NOP || count !== 2'd0) begin
      errors++; $display("FAIL stream_drain: got v%b %h cnt %0d exp v0 %h 0", out_valid, out_data, count, NOP);
    end
  endtask

  task automatic test_x0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0077; in_w_addr = '0; in_w_req = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_w_addr !== '0 || out_w_req !== 1'b0 || out_data !== 16'h0077) begin
      errors++; $display("FAIL x0_suppress: got v%b addr %0d req %b data %h exp v1 0 0 0077", out_valid, out_w_addr, out_w_req, out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_skid;
    logic [DATA_W-1:0] pending [$];
    logic [DATA_W-1:0] emitted [$];
    logic [DATA_W-1:0] exp_seq [3];
    exp_seq[0] = 16'h00A1; exp_seq[1] = 16'h00B2; exp_seq[2] = 16'h00C3;
    out_ready = 1'b0; in_w_addr = 5'd4; in_w_req = 1'b1; in_valid = 1'b1;
    in_data = exp_seq[0];
    tick();
    vectors++;
    if (count !== 2'd1 || out_data !== exp_seq[0]) begin
      errors++; $display("FAIL skid_a_in: got cnt %0d data %h exp 1 %h", count, out_data, exp_seq[0]);
    end
    in_data = exp_seq[1]; #1;
    vectors++;
    if (in_ready !== SKID) begin errors++; $display("FAIL skid_in_ready_one: got %b exp %b", in_ready, SKID); end
    tick();
    vectors++;
    if (count !== MAXC || in_ready !== 1'b0) begin
      errors++; $display("FAIL skid_full: got cnt %0d rdy %b exp %0d 0", count, in_ready, MAXC);
    end
    if (!SKID) pending.push_back(exp_seq[1]);
    pending.push_back(exp_seq[2]);
    in_data = pending[0];
    tick();
    vectors++;
    if (count !== MAXC || out_data !== exp_seq[0]) begin
      errors++; $display("FAIL skid_hold: got cnt %0d data %h exp %0d %h", count, out_data, MAXC, exp_seq[0]);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (pending.size() > 0);
      if (pending.size() > 0) in_data = pending[0];
      tick();
      if (last_acc && pending.size() > 0) void'(pending.pop_front());
      if (last_emit) emitted.push_back(last_emit_data);
      if (pending.size() == 0 && !out_valid) break;
    end
    in_valid = 1'b0;
    vectors++;
    if (emitted.size() != 3) begin errors++; $display("FAIL skid_emit_count: got %0d exp 3", emitted.size()); end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= emitted.size() || emitted[i] !== exp_seq[i]) begin
        errors++; $display("FAIL skid_order[%0d]: got %h exp %h", i, (i < emitted.size()) ? emitted[i] : 16'hxxxx, exp_seq[i]);
      end
    end
  endtask

  task automatic test_flush;
    fill(16'h0031, 16'h0032);
    vectors++;
    if (count !== MAXC) begin errors++; $display("FAIL flush_prefill: got cnt %0d exp %0d", count, MAXC); end
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h003D; in_w_addr = 5'd9;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP || out_w_req !== 1'b0 || out_w_addr !== '0) begin
      errors++; $display("FAIL flush_clear: got cnt %0d v%b data %h req %b addr %0d exp 0 v0 %h 0 0", count, out_valid, out_data, out_w_req, out_w_addr, NOP);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d]: got v%b data %h exp v0", i, out_valid, out_data); end
    end
  endtask

  task automatic test_rdy_freeze;
    out_ready = 1'b1; in_valid = 1'b1; in_w_addr = 5'd6; in_w_req = 1'b1; in_data = 16'h0020;
    tick();
    vectors++;
    if (out_data !== 16'h0020) begin errors++; $display("FAIL rdy_pre: got %h exp 0020", out_data); end
    rdy = 1'b0; in_data = 16'h0021;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_data !== 16'h0020 || count !== 2'd1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL rdy_frozen[%0d]: got v%b data %h cnt %0d rdy %b exp v1 0020 1 0", i, out_valid, out_data, count, in_ready);
      end
    end
    rdy = 1'b1;
    tick();
    vectors++;
    if (out_data !== 16'h0021) begin errors++; $display("FAIL rdy_resume1: got %h exp 0021", out_data); end
    in_data = 16'h0022;
    tick();
    vectors++;
    if (out_data !== 16'h0022) begin errors++; $display("FAIL rdy_resume2: got %h exp 0022", out_data); end
    in_valid = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rdy_drain: got v%b exp v0", out_valid); end
  endtask

  task automatic test_rst_mid;
    fill(16'h0041, 16'h0042);
    rst = 1'b1;
    tick();
    vectors++;
    if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== NOP || out_w_req !== 1'b0 || out_w_addr !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got cnt %0d v%b data %h req %b addr %0d rdy %b exp 0 v0 %h 0 0 0", count, out_valid, out_data, out_w_req, out_w_addr, in_ready, NOP);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ghost[%0d]: got v%b data %h exp v0", i, out_valid, out_data); end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_x0();
    test_skid();
    test_flush();
    test_rdy_freeze();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
